pixel_line_feeder: RTL and testbench

- Transmit side of the line-buffer windowing stage: reads a row-major F×F image from a synchronous-read pixel memory.
- Streams it one pixel per cycle into the 4-line-buffer window generator.
- Flow control is line-granular credits: the downstream buffer frees one line and raises its line-consumed interrupt, and the feeder then releases one more line.
- Sits between image BRAM and the conv window generator, controlled by a top-level start/done handshake.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/line_credit_counter.sv | 65 ++++++
 rtl/pixel_line_feeder.sv | 195 +++++++++++++++++++
 tb/tb_pixel_line_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// ============================================================================
// Package : cnn_pkg
// Purpose : Shared definitions for the pixel line feeder: default image
//           geometry, pixel type, feeder FSM encoding and the memory address
//           width derivation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

   localparam int F_DEF = 28;   // image width/height in pixels
   localparam int B_DEF = 8;    // pixel bit width

   typedef logic [B_DEF-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FLUSH = 2'd3
   } feeder_state_t;

   // Address width needed to reach every pixel of an f x f image.
   function automatic int addr_width(input int f);
      return (f * f > 1) ? $clog2(f * f) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/line_credit_counter.sv
// ============================================================================
// Module  : line_credit_counter
// Purpose : Rising-edge detector on the line-consumed interrupt plus a
//           saturating up/down line credit counter (range 0..NLB).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module line_credit_counter
   import cnn_pkg::*;
#(
   parameter int NLB = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_intr,
   input  logic                       i_load,
   input  logic                       i_dec,
   output logic                       o_inc_edge,
   output logic                       o_credit_avail,
   output logic [$clog2(NLB+1)-1:0]   o_credits
);

   localparam int            CW      = $clog2(NLB + 1);
   localparam logic [CW-1:0] C_MAX   = CW'(NLB);

   logic          intr_q;
   logic [CW-1:0] credits_q;
   logic [CW-1:0] credits_d;

   // A level held high counts once: only the 0->1 transition is a credit.
   assign o_inc_edge     = i_intr && !intr_q;
   assign o_credit_avail = (credits_q != '0);
   assign o_credits      = credits_q;

   // Next credit value: load wins, a simultaneous +1/-1 cancels, saturate at both ends.
   always_comb begin
      credits_d = credits_q;
      if (i_load) begin
         credits_d = C_MAX;
      end else if (o_inc_edge && !i_dec) begin
         if (credits_q != C_MAX) begin
            credits_d = credits_q + 1'b1;
         end
      end else if (i_dec && !o_inc_edge) begin
         if (credits_q != '0) begin
            credits_d = credits_q - 1'b1;
         end
      end
   end

   // Edge-detect history and credit register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         intr_q    <= 1'b0;
         credits_q <= C_MAX;
      end else begin
         intr_q    <= i_intr;
         credits_q <= credits_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pixel_line_feeder.sv
// ============================================================================
// Module  : pixel_line_feeder
// Purpose : Reads a row-major F x F image from synchronous-read memory and
//           streams it one pixel per cycle to the line-buffer window
//           generator, releasing one line per available line credit.
// Config  : define PIXEL_FEEDER_PAD_EN to emit an all-zero line before the
//           first and after the last image line (F+2 lines per frame).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_line_feeder
   import cnn_pkg::*;
#(
   parameter int F      = F_DEF,
   parameter int B      = B_DEF,
   parameter int NLB    = 4,
   parameter int ADDR_W = addr_width(F)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_mem_rd,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [B-1:0]      i_mem_data,
   output logic [B-1:0]      o_pixel_data,
   output logic              o_pixel_data_valid,
   input  logic              i_intr
);

`ifdef PIXEL_FEEDER_PAD_EN
   localparam int LINES = F + 2;
`else
   localparam int LINES = F;
`endif
   localparam int ROW_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int COL_W = (F > 1) ? $clog2(F) : 1;
   localparam int CW    = $clog2(NLB + 1);

   feeder_state_t     state_q;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic              iss_q;     // a pixel slot (real or pad) was issued
   logic              rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;

   logic              w_inc_edge;
   logic              w_credit_avail;
   logic [CW-1:0]     w_credits;
   logic              w_last_col;
   logic              w_last_row;
   logic              w_line_start;
   logic              w_issue;
   logic              w_dec;
   logic              w_load;
   logic              w_credit_left;
   logic              w_pad_line;
   logic [ADDR_W-1:0] w_addr;

   assign w_last_col   = (col_q == COL_W'(F - 1));
   assign w_last_row   = (row_q == ROW_W'(LINES - 1));
   assign w_line_start = (col_q == '0);
   assign w_load       = (state_q == ST_IDLE) && i_start;

   // A line only starts with a credit in hand; mid-line pixels always go.
   assign w_issue = (state_q == ST_SEND) && (!w_line_start || w_credit_avail);
   assign w_dec   = w_issue && w_line_start;

   // Whether a credit remains after this cycle's line start and interrupt edge.
   assign w_credit_left = w_inc_edge || (w_credits > CW'(w_dec));

   // Line index to memory address; pad lines shift the image down by one row.
   always_comb begin
      w_pad_line = 1'b0;
      w_addr     = ADDR_W'(row_q) * ADDR_W'(F) + ADDR_W'(col_q);
`ifdef PIXEL_FEEDER_PAD_EN
      w_pad_line = (row_q == '0) || w_last_row;
      w_addr     = ADDR_W'(row_q - ROW_W'(1)) * ADDR_W'(F) + ADDR_W'(col_q);
`endif
   end

   line_credit_counter #(
      .NLB            (NLB)
   ) u_credits (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_intr         (i_intr),
      .i_load         (w_load),
      .i_dec          (w_dec),
      .o_inc_edge     (w_inc_edge),
      .o_credit_avail (w_credit_avail),
      .o_credits      (w_credits)
   );

   // Control FSM with row/col walk and the registered read/valid pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         iss_q   <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         iss_q   <= w_issue;
         rd_q    <= w_issue && !w_pad_line;
         valid_q <= iss_q;
         done_q  <= 1'b0;
         if (w_issue) begin
            addr_q <= w_addr;
         end
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_q <= ST_SEND;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            ST_SEND: begin
               if (w_issue) begin
                  if (w_last_col) begin
                     col_q <= '0;
                     if (w_last_row) begin
                        state_q <= ST_FLUSH;
                     end else begin
                        row_q <= row_q + 1'b1;
                        if (!w_credit_left) begin
                           state_q <= ST_WAIT;
                        end
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (w_credit_avail) begin
                  state_q <= ST_SEND;
               end
            end
            ST_FLUSH: begin
               // Hold until the final slot has left the read stage so that
               // done lands in the cycle after the last valid pixel.
               if (!iss_q) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef PIXEL_FEEDER_PAD_EN
   logic pad_q;
   logic pad_vq_q;

   // Track pad slots alongside the read so their data can be zeroed.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pad_q    <= 1'b0;
         pad_vq_q <= 1'b0;
      end else begin
         pad_q    <= w_issue && w_pad_line;
         pad_vq_q <= pad_q;
      end
   end

   // The memory's own output register is the data pipeline stage.
   assign o_pixel_data = (valid_q && !pad_vq_q) ? i_mem_data : '0;
`else
   // The memory's own output register is the data pipeline stage.
   assign o_pixel_data = valid_q ? i_mem_data : '0;
`endif

   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_mem_rd           = rd_q;
   assign o_mem_addr         = addr_q;
   assign o_pixel_data_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_line_feeder.sv
// ============================================================================
// Module  : tb_pixel_line_feeder
// Purpose : Scoreboard bench for pixel_line_feeder (F=28, NLB=4, memory
//           holding addr[7:0]); also follows PIXEL_FEEDER_PAD_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_line_feeder;
   import cnn_pkg::*;

   localparam int F   = 28;
   localparam int B   = 8;
   localparam int NLB = 4;
   localparam int AW  = addr_width(F);
`ifdef PIXEL_FEEDER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int L    = PAD ? F + 2 : F;
   localparam int NPIX = L * F;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic          intr  = 1'b0;
   logic          busy, done, mem_rd, pix_valid;
   logic [AW-1:0] mem_addr;
   logic [B-1:0]  mem_data;
   logic [B-1:0]  pix;
   logic [B-1:0]  mem [0:F*F-1];

   typedef struct {
      logic [B-1:0] data;
      bit           pad;
   } exp_t;

   exp_t exp_q[$];
   int   addr_q[$];
   exp_t mon_e;
   int   n_cmp = 0, n_err = 0;
   int   n_valid = 0, n_rd = 0, n_done = 0;
   int   cyc = 0, busy_cyc = 0, first_lat = -1;
   logic rd_d = 1'b0, busy_d = 1'b0;
   bit   auto_on = 1'b0;
   int   auto_thr = 0;

   pixel_line_feeder #(
      .F(F), .B(B), .NLB(NLB), .ADDR_W(AW)
   ) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_start            (start),
      .o_busy             (busy),
      .o_done             (done),
      .o_mem_rd           (mem_rd),
      .o_mem_addr         (mem_addr),
      .i_mem_data         (mem_data),
      .o_pixel_data       (pix),
      .o_pixel_data_valid (pix_valid),
      .i_intr             (intr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read pixel memory.
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents a read or a pixel.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && !busy_d) busy_cyc = cyc;
         if (mem_rd) begin
            n_rd++;
            if (addr_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_read: addr %0d with empty queue", mem_addr);
            end else begin
               chk("read_addr", int'(mem_addr), addr_q.pop_front());
            end
         end
         if (pix_valid) begin
            if (first_lat < 0) first_lat = cyc - busy_cyc;
            n_valid++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_pixel: data %0d with empty queue", pix);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pixel_data", int'(pix), int'(mon_e.data));
               chk("pixel_read_before", int'(rd_d), mon_e.pad ? 0 : 1);
            end
         end
         if (done) begin
            n_done++;
            chk("busy_low_at_done", int'(busy), 0);
         end
      end
      rd_d   = mem_rd;
      busy_d = busy;
   end

   // One cycle; optionally returns a credit each time another line has drained.
   task automatic step();
      @(negedge clk);
      if (auto_on) begin
         if (intr) intr = 1'b0;
         else if (n_valid >= auto_thr) begin
            intr = 1'b1;
            auto_thr += F;
         end
      end
   endtask

   task automatic do_reset();
      auto_on = 1'b0;
      intr    = 1'b0;
      start   = 1'b0;
      rst     = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_mem_rd", int'(mem_rd), 0);
      chk("rst_valid", int'(pix_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pixel", int'(pix), 0);
      step();
      step();
      exp_q.delete();
      addr_q.delete();
      rst = 1'b0;
      step();
   endtask

   // Queue the whole frame's expected stream, then pulse start.
   task automatic start_frame();
      for (int l = 0; l < L; l++) begin
         for (int c = 0; c < F; c++) begin
            exp_t e;
            bit   pd;
            int   r;
            pd     = PAD && (l == 0 || l == L - 1);
            r      = PAD ? l - 1 : l;
            e.data = pd ? '0 : B'((r * F + c) & 255);
            e.pad  = pd;
            exp_q.push_back(e);
            if (!pd) addr_q.push_back(r * F + c);
         end
      end
      n_valid   = 0;
      n_rd      = 0;
      n_done    = 0;
      first_lat = -1;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_valid(int n, int budget, string name);
      int k = 0;
      while (n_valid < n && k < budget) begin
         step();
         k++;
      end
      chk(name, n_valid, n);
   endtask

   task automatic finish_frame(string name);
      int k = 0;
      while (n_done == 0 && k < 4000) begin
         step();
         k++;
      end
      repeat (4) step();
      auto_on = 1'b0;
      intr    = 1'b0;
      chk({name, "_done_pulses"}, n_done, 1);
      chk({name, "_valid_total"}, n_valid, NPIX);
      chk({name, "_read_total"}, n_rd, F * F);
      chk({name, "_queue_left"}, exp_q.size(), 0);
      chk({name, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < F * F; i++) mem[i] = B'(i & 255);

      // Full frame with a credit returned after every drained line.
      do_reset();
      start_frame();
      auto_thr = F;
      auto_on  = 1'b1;
      finish_frame("t1");
      chk("t1_first_valid_latency", first_lat, 2);

      // No credits returned: four lines, stall, then exactly one more line.
      do_reset();
      start_frame();
      wait_valid(4 * F, 400, "t2_reach_4_lines");
      repeat (40) step();
      chk("t2_stall_count", n_valid, 4 * F);
      chk("t2_stall_mem_rd", int'(mem_rd), 0);
      chk("t2_stall_busy", int'(busy), 1);
      intr = 1'b1; step(); intr = 1'b0;
      repeat (80) step();
      chk("t2_one_more_line", n_valid, 5 * F);
      chk("t2_restall_mem_rd", int'(mem_rd), 0);
      auto_thr = n_valid;
      auto_on  = 1'b1;
      finish_frame("t2");

      // Five edges during line 0 saturate credits at NLB: 1 + 4 lines.
      do_reset();
      start_frame();
      step(); step();
      repeat (5) begin
         intr = 1'b1; step();
         intr = 1'b0; step();
      end
      repeat (250) step();
      chk("t3_saturated_lines", n_valid, 5 * F);

      // Edge coinciding with line 1 start: credits stay at 3, 5 lines total.
      do_reset();
      start_frame();
      repeat (28) step();
      intr = 1'b1; step(); intr = 1'b0;
      repeat (250) step();
      chk("t3_coincident_edge", n_valid, 5 * F);

      // Level held 10 cycles is one credit; start during SEND is ignored.
      do_reset();
      start_frame();
      repeat (5) step();
      intr = 1'b1;
      repeat (10) step();
      intr = 1'b0;
      repeat (5) step();
      start = 1'b1; step(); start = 1'b0;
      repeat (250) step();
      chk("t4_held_intr_lines", n_valid, 5 * F);
      auto_thr = n_valid;
      auto_on  = 1'b1;
      finish_frame("t4");

      // Reset mid-line at row 5 col 13, then a clean restart from address 0.
      do_reset();
      start_frame();
      auto_thr = F;
      auto_on  = 1'b1;
      k = 0;
      while (!(mem_rd && int'(mem_addr) == 5 * F + 13) && k < 1000) begin
         step();
         k++;
      end
      chk("t5_reached_addr", int'(mem_addr), 5 * F + 13);
      do_reset();
      start_frame();
      wait_valid(4 * F, 400, "t5_restart_4_lines");
      repeat (40) step();
      chk("t5_restart_stall", n_valid, 4 * F);
      chk("t5_restart_latency", first_lat, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
